// File: rtl/unified_mem_arbiter.sv
// Arbitrates the IF and MEM pipeline stages onto one single-ported memory, with
// DM-first priority, a starvation guard for IF and an ack timeout.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam int TMO_W    = $clog2(TIMEOUT + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                err_q, err_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

    logic force_if, grant_dm, grant_if;

    // IF wins only once DM has been granted STARVE_MAX times in a row over a waiting fetch.
    assign force_if = if_req_i && (starve_q == STARVE_W'(STARVE_MAX));
    assign grant_dm = dm_req_i && !force_if;
    assign grant_if = if_req_i && !grant_dm;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        starve_d    = starve_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_dm || grant_if) begin
                    state_d     = ST_BUSY;
                    owner_d     = grant_dm ? OWN_DM : OWN_IF;
                    mem_we_d    = grant_dm && dm_we_i;
                    mem_addr_d  = grant_dm ? dm_addr_i : if_addr_i;
                    mem_wdata_d = grant_dm ? dm_wdata_i : '0;
                    tmo_d       = TMO_W'(1);
                    err_d       = 1'b0;
                end
            end
            ST_BUSY: begin
                if (mem_ack_i) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    if (!mem_we_q) begin
                        if (owner_q == OWN_DM) dm_rdata_d = mem_rdata_i;
                        else                   if_data_d  = mem_rdata_i;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT)) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    if (owner_q == OWN_DM) dm_rdata_d = '0;
                    else                   if_data_d  = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (!if_req_i) begin
            starve_d = '0;
        end else if (state_q == ST_IDLE && grant_if) begin
            starve_d = '0;
        end else if (state_q == ST_IDLE && grant_dm && !force_if) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            starve_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            // NOTE: data registers are reset too, since their outputs must read 0 out of reset.
            if_data_q   <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            starve_q    <= starve_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_en_o    = (state_q == ST_BUSY);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_data_o   = if_data_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign if_ready_o  = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign dm_ready_o  = (state_q == ST_RESP) && (owner_q == OWN_DM);
    assign err_o       = (state_q == ST_RESP) && err_q;
    assign stall_o     = (if_req_i && !if_ready_o) || (dm_req_i && !dm_ready_o);

endmodule
